// File: rtl/led_shifter.sv
// led_shifter: reads every channel word of a frame out of the framebuffer
// (highest address first) and shifts it MSB first into a daisy-chained DM633
// driver chain. A latch pulse at the end of the frame transfers the data to
// the PWM outputs.
//
// Optional feature macro: LED_SHIFTER_AUTOREFRESH_EN (frames repeat
// continuously after the first start request, until reset).
//
// Ports:
//   i_clk    system clock, rising edge
//   i_rst_n  asynchronous active-low reset
//   i_start  start-frame request, sampled in IDLE only
//   o_busy   high from leaving IDLE until returning to IDLE
//   o_done   one-cycle pulse at frame completion
//   o_ren    framebuffer read enable
//   o_raddr  framebuffer read address
//   i_data   framebuffer read data, valid the cycle after o_ren
//   o_dck    DM633 shift clock
//   o_dai    DM633 serial data
//   o_lat    DM633 latch
module led_shifter #(
  parameter  int unsigned c_ledboards = 30,
  parameter  int unsigned c_bps       = 12,
  parameter  int unsigned c_clkdiv    = 2,
  parameter  int unsigned c_lat       = 2,
  localparam int unsigned c_channels  = c_ledboards * 32,
  localparam int unsigned c_addr_w    = (c_channels > 1) ? $clog2(c_channels) : 1
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_start,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_ren,
  output logic [c_addr_w-1:0] o_raddr,
  input  logic [c_bps-1:0]    i_data,
  output logic                o_dck,
  output logic                o_dai,
  output logic                o_lat
);

  localparam int unsigned c_div_w  = (c_clkdiv > 1) ? $clog2(c_clkdiv) : 1;
  localparam int unsigned c_bit_w  = (c_bps > 1) ? $clog2(c_bps) : 1;
  localparam int unsigned c_latc_w = (c_lat > 1) ? $clog2(c_lat) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_SHIFT,
    S_LATCH,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [c_addr_w-1:0]   idx_q, idx_d;
  logic [c_bps-1:0]      sr_q, sr_d;
  logic [c_div_w-1:0]    div_q, div_d;
  logic                  hi_q, hi_d;
  logic [c_bit_w-1:0]    bit_q, bit_d;
  logic [c_latc_w-1:0]   latc_q, latc_d;

  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  ren_q, ren_d;
  logic [c_addr_w-1:0]   raddr_q, raddr_d;
  logic                  dck_q, dck_d;
  logic                  dai_q, dai_d;
  logic                  lat_q, lat_d;

  // Next-state logic; outputs are derived from the next state so that the
  // registered outputs line up with the state they belong to.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    sr_d    = sr_q;
    div_d   = div_q;
    hi_d    = hi_q;
    bit_d   = bit_q;
    latc_d  = latc_q;

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d = S_FETCH;
          idx_d   = c_addr_w'(c_channels - 1);
        end
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        sr_d    = i_data;
        div_d   = '0;
        hi_d    = 1'b0;
        bit_d   = '0;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (div_q == c_div_w'(c_clkdiv - 1)) begin
          div_d = '0;
          if (!hi_q) begin
            hi_d = 1'b1;
          end else begin
            // End of the high phase: advance to the next bit.
            hi_d = 1'b0;
            sr_d = sr_q << 1;
            if (bit_q == c_bit_w'(c_bps - 1)) begin
              bit_d = '0;
              if (idx_q == '0) begin
                latc_d  = '0;
                state_d = S_LATCH;
              end else begin
                idx_d   = idx_q - c_addr_w'(1);
                state_d = S_FETCH;
              end
            end else begin
              bit_d = bit_q + c_bit_w'(1);
            end
          end
        end else begin
          div_d = div_q + c_div_w'(1);
        end
      end
      S_LATCH: begin
        if (latc_q == c_latc_w'(c_lat - 1)) state_d = S_DONE;
        else                                 latc_d  = latc_q + c_latc_w'(1);
      end
      S_DONE: begin
`ifdef LED_SHIFTER_AUTOREFRESH_EN
        state_d = S_FETCH;
        idx_d   = c_addr_w'(c_channels - 1);
`else
        state_d = S_IDLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase

    busy_d  = (state_d != S_IDLE);
    done_d  = (state_d == S_DONE);
    ren_d   = (state_d == S_FETCH);
    raddr_d = (state_d == S_FETCH) ? idx_d : '0;
    dck_d   = (state_d == S_SHIFT) && hi_d;
    dai_d   = (state_d == S_SHIFT) && sr_d[c_bps-1];
    lat_d   = (state_d == S_LATCH);
  end

  // State and output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      sr_q    <= '0;
      div_q   <= '0;
      hi_q    <= 1'b0;
      bit_q   <= '0;
      latc_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ren_q   <= 1'b0;
      raddr_q <= '0;
      dck_q   <= 1'b0;
      dai_q   <= 1'b0;
      lat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sr_q    <= sr_d;
      div_q   <= div_d;
      hi_q    <= hi_d;
      bit_q   <= bit_d;
      latc_q  <= latc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ren_q   <= ren_d;
      raddr_q <= raddr_d;
      dck_q   <= dck_d;
      dai_q   <= dai_d;
      lat_q   <= lat_d;
    end
  end

  assign o_busy  = busy_q;
  assign o_done  = done_q;
  assign o_ren   = ren_q;
  assign o_raddr = raddr_q;
  assign o_dck   = dck_q;
  assign o_dai   = dai_q;
  assign o_lat   = lat_q;

endmodule

// File: tb/tb_led_shifter.sv
// Bench for led_shifter: dut_a (1 board, clkdiv 1, lat 2) against a
// framebuffer model word[n] = n ^ mask; dut_b (1 board, clkdiv 3, lat 4)
// against a framebuffer holding 0xA5C everywhere.
module tb_led_shifter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        a_start, a_busy, a_done, a_ren, a_dck, a_dai, a_lat;
  logic [4:0]  a_raddr;
  logic [11:0] a_data, a_mask;
  logic        b_start, b_busy, b_done, b_ren, b_dck, b_dai, b_lat;
  logic [4:0]  b_raddr;
  logic [11:0] b_data;

  led_shifter #(.c_ledboards(1), .c_bps(12), .c_clkdiv(1), .c_lat(2)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(a_start), .o_busy(a_busy),
    .o_done(a_done), .o_ren(a_ren), .o_raddr(a_raddr), .i_data(a_data),
    .o_dck(a_dck), .o_dai(a_dai), .o_lat(a_lat));

  led_shifter #(.c_ledboards(1), .c_bps(12), .c_clkdiv(3), .c_lat(4)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(b_start), .o_busy(b_busy),
    .o_done(b_done), .o_ren(b_ren), .o_raddr(b_raddr), .i_data(b_data),
    .o_dck(b_dck), .o_dai(b_dai), .o_lat(b_lat));

  // Framebuffer models: valid data only the cycle after a read, junk otherwise.
  always @(posedge clk) begin
    if (a_ren) a_data <= 12'(a_raddr) ^ a_mask;
    else       a_data <= 12'($urandom);
    if (b_ren) b_data <= 12'hA5C;
    else       b_data <= 12'($urandom);
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Scoreboards: expected read addresses and serial bits.
  int a_addrs[$];
  bit a_bits[$];
  bit b_bits[$];

  task automatic push_a_frame(input logic [11:0] mask);
    logic [11:0] w;
    for (int n = 31; n >= 0; n--) begin
      a_addrs.push_back(n);
      w = 12'(n) ^ mask;
      for (int b = 11; b >= 0; b--) a_bits.push_back(w[b]);
    end
  endtask

  // Monitor A: address/bit scoreboard and output-relationship checks.
  logic a_pdck = 1'b0, a_pdai = 1'b0;
  always @(negedge clk) begin
    if (a_ren) begin
      if (a_addrs.size() == 0) check("a_raddr_unexpected", 1, 0);
      else                     check("a_raddr", int'(a_raddr), a_addrs.pop_front());
    end
    if (a_dck && !a_pdck) begin
      if (a_bits.size() == 0) check("a_dai_unexpected", 1, 0);
      else                    check("a_dai", int'(a_dai), int'(a_bits.pop_front()));
    end
    if (a_dai != a_pdai) check("a_dai_change_dck_high", int'(a_dck), 0);
    if (a_lat)           check("a_lat_dck_overlap", int'(a_dck), 0);
    a_pdck <= a_dck;
    a_pdai <= a_dai;
  end

  // Monitor B: bit scoreboard plus phase, setup/hold and latch timing.
  logic b_pdck = 1'b0, b_pdai = 1'b0, b_plat = 1'b0, b_pdone = 1'b0;
  int   b_hi_run = 0, b_lat_run = 0, b_dai_stable = 0;
  always @(negedge clk) begin
    if (b_dck && !b_pdck) begin
      if (b_bits.size() == 0) check("b_dai_unexpected", 1, 0);
      else                    check("b_dai", int'(b_dai), int'(b_bits.pop_front()));
      check("b_dai_setup", int'((b_dai == b_pdai) && (b_dai_stable >= 3)), 1);
    end
    if (!b_dck && b_pdck)  check("b_dck_high_len", b_hi_run, 3);
    if (b_dai != b_pdai)   check("b_dai_change_dck_high", int'(b_dck), 0);
    if (b_lat)             check("b_lat_dck_overlap", int'(b_dck), 0);
    if (b_lat && !b_plat)  check("b_lat_after_last_fall", int'(b_pdck), 1);
    if (!b_lat && b_plat) begin
      check("b_lat_len", b_lat_run, 4);
      check("b_done_after_lat", int'(b_done), 1);
    end
    if (b_pdone)           check("b_done_one_cycle", int'(b_done), 0);
    b_hi_run     <= b_dck ? b_hi_run + 1 : 0;
    b_lat_run    <= b_lat ? b_lat_run + 1 : 0;
    b_dai_stable <= (b_dai == b_pdai) ? b_dai_stable + 1 : 1;
    b_pdck  <= b_dck;
    b_pdai  <= b_dai;
    b_plat  <= b_lat;
    b_pdone <= b_done;
  end

  // One frame on dut_a; cyc counts cycles from the start sample edge to o_done.
  task automatic run_a(input int hold, input logic [11:0] mask, output int cyc);
    @(negedge clk);
    a_mask = mask;
    push_a_frame(mask);
    a_start = 1'b1;
    @(posedge clk);
    cyc = 0;
    while (cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (cyc >= hold) a_start = 1'b0;
      if (cyc == 1) check("a_busy_rise", int'(a_busy), 1);
      if (a_done) break;
    end
  endtask

  typedef struct {
    int          hold;
    logic [11:0] mask;
    int          exp_cyc;
  } vec_t;

  vec_t       vecs[3];
  int         cyc;
  int         ndone;
  int         last;
  int         busy_low;
  logic [11:0] pat;

  initial begin
    vecs[0] = '{1,   12'h000, 835};
    vecs[1] = '{2,   12'hFFF, 835};
    vecs[2] = '{400, 12'h5A5, 835};

    rst_n   = 1'b0;
    a_start = 1'b0;
    b_start = 1'b0;
    a_mask  = '0;
    repeat (3) @(negedge clk);
    check("rst_busy",  int'(a_busy),  0);
    check("rst_done",  int'(a_done),  0);
    check("rst_ren",   int'(a_ren),   0);
    check("rst_raddr", int'(a_raddr), 0);
    check("rst_dck",   int'(a_dck),   0);
    check("rst_dai",   int'(a_dai),   0);
    check("rst_lat",   int'(a_lat),   0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_no_start", int'(a_busy), 0);

    // dut_b: 0xA5C words with 3-cycle DCK phases and a 4-cycle latch.
    pat = 12'hA5C;
    for (int w = 0; w < 32; w++)
      for (int b = 11; b >= 0; b--) b_bits.push_back(pat[b]);
    b_start = 1'b1;
    @(posedge clk);
    cyc = 0;
    while (cyc < 5000) begin
      @(negedge clk);
      cyc++;
      b_start = 1'b0;
      if (b_done) break;
    end
    check("b_frame_cycles", cyc, 2373);
    check("b_bits_left", b_bits.size(), 0);
`ifdef LED_SHIFTER_AUTOREFRESH_EN
    #1 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    b_bits.delete();
`endif

`ifndef LED_SHIFTER_AUTOREFRESH_EN
    for (int i = 0; i < 3; i++) begin
      run_a(vecs[i].hold, vecs[i].mask, cyc);
      check("a_frame_cycles", cyc, vecs[i].exp_cyc);
      check("a_bits_left", a_bits.size(), 0);
      check("a_addrs_left", a_addrs.size(), 0);
      @(negedge clk);
      check("a_idle_after_done", int'(a_busy), 0);
      check("a_done_one_cycle", int'(a_done), 0);
    end

    // i_start held high: one frame per o_done, restart in first IDLE cycle.
    @(negedge clk);
    a_mask = '0;
    push_a_frame('0);
    push_a_frame('0);
    a_start = 1'b1;
    @(posedge clk);
    cyc = 0;
    while (cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (a_done) break;
    end
    check("held_frame_cycles", cyc, 835);
    @(negedge clk);
    check("held_idle_gap", int'(a_busy), 0);
    @(negedge clk);
    check("held_restart_busy", int'(a_busy), 1);
    check("held_restart_ren", int'(a_ren), 1);
    a_start = 1'b0;
    cyc = 0;
    while (cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (a_done) break;
    end
    check("held_second_cycles", cyc, 834);
    repeat (5) @(negedge clk);
    check("held_no_requeue", int'(a_busy), 0);
    check("held_bits_left", a_bits.size(), 0);
`else
    // Autorefresh: one pulse, frames repeat with o_busy held high.
    @(negedge clk);
    a_mask = '0;
    push_a_frame('0);
    push_a_frame('0);
    push_a_frame('0);
    a_start = 1'b1;
    @(posedge clk);
    cyc = 0;
    ndone = 0;
    last = 0;
    busy_low = 0;
    while (ndone < 3 && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      a_start = 1'b0;
      if (!a_busy) busy_low++;
      if (a_done) begin
        ndone++;
        check("auto_done_spacing", cyc - last, 835);
        last = cyc;
      end
    end
    check("auto_done_count", ndone, 3);
    check("auto_busy_low", busy_low, 0);
    check("auto_bits_left", a_bits.size(), 0);
    #1 rst_n = 1'b0;
    a_bits.delete();
    a_addrs.delete();
    @(negedge clk);
    rst_n = 1'b1;
`endif

    // Asynchronous reset while DCK is high.
    @(negedge clk);
    a_mask = '0;
    push_a_frame('0);
    a_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a_start = 1'b0;
    cyc = 0;
    while (!a_dck && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("rst_wait_dck", int'(a_dck), 1);
    #1 rst_n = 1'b0;
    #1;
    check("arst_dck",   int'(a_dck),   0);
    check("arst_dai",   int'(a_dai),   0);
    check("arst_lat",   int'(a_lat),   0);
    check("arst_ren",   int'(a_ren),   0);
    check("arst_raddr", int'(a_raddr), 0);
    check("arst_busy",  int'(a_busy),  0);
    check("arst_done",  int'(a_done),  0);
    a_bits.delete();
    a_addrs.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("post_rst_busy", int'(a_busy), 0);
    check("post_rst_ren",  int'(a_ren),  0);
    check("post_rst_dck",  int'(a_dck),  0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
